// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared memory-access types for the multicycle core and its
//               memory responder: RV32I access widths (funct3 encoding) and
//               the responder's handshake state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // RV32I load/store width, encoded exactly as funct3 so decode can cast directly
    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memresp_state_t;

    // Wait-state counter width; supports WAIT_STATES up to 15
    localparam int c_WAIT_CNT_W = 4;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mc_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : mc_load_ext
// Description : Combinational load lane select and sign/zero extension for
//               RV32I LB/LH/LW/LBU/LHU. Shared with the single-cycle datapath.
// Ports       : i_word   [31:0] aligned 32-bit word read from memory
//               i_lane   [1:0]  byte address low bits (byte lane / half select)
//               i_funct3 [2:0]  access width (mem_width_t encoding)
//               o_data   [31:0] extended load result; 0 for unsupported widths
// Revision    : 1.0 - initial release
// ============================================================================
module mc_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            MW_B:    o_data = {{24{w_byte[7]}}, w_byte};
            MW_BU:   o_data = {24'd0, w_byte};
            MW_H:    o_data = {{16{w_half[15]}}, w_half};
            MW_HU:   o_data = {16'd0, w_half};
            MW_W:    o_data = i_word;
            default: o_data = 32'd0;
        endcase
    end

endmodule : mc_load_ext
`default_nettype wire

// File: rtl/mc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mc_mem_responder
// Description : Memory-side responder for the multicycle core. Accepts one
//               fetch/load/store request at a time into a unified word RAM,
//               inserts WAIT_STATES wait cycles, then pulses a response.
//               Handles RV32I byte/half/word lanes, load extension, store
//               byte merging, and faults (misaligned, out of range, width).
// Parameters  : DEPTH_WORDS RAM depth in 32-bit words
//               WAIT_STATES extra cycles between accept and response (0..15)
//               INIT_FILE   initial image name; RAM starts uninitialised
// Ports       : clk, reset          clock / synchronous active-high reset
//               req_valid/req_ready request handshake (ready only in IDLE)
//               req_we              1 = store, 0 = load/fetch
//               req_addr [31:0]     byte address
//               req_wdata[31:0]     store data in low bits
//               req_funct3[2:0]     access width
//               resp_valid          one-cycle completion pulse
//               resp_rdata[31:0]    extended load data, else 0
//               resp_fault          error flag, qualified by resp_valid
// Revision    : 1.0 - initial release
// ============================================================================
module mc_mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int                      c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0]             c_DEPTH32   = 32'(DEPTH_WORDS);
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_INIT = (WAIT_STATES > 0) ?
                                                      c_WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    memresp_state_t          r_state;
    memresp_state_t          w_state_nxt;
    logic [c_WAIT_CNT_W-1:0] r_cnt;
    logic [c_WAIT_CNT_W-1:0] w_cnt_nxt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rword;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_oor;
    logic               w_bad_width;
    logic               w_misalign;
    logic               w_fault;
    logic [31:0]        w_ext;
    logic [3:0]         w_be;
    logic [31:0]        w_wlane;
    logic               w_wr_en;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_WAIT_INIT;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture; the core may drop its request lines after accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= 3'b010;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
        end
    end

    // ------------------------------------------------------------------
    // Fault checks on the captured request
    // ------------------------------------------------------------------
    always_comb begin
        w_oor = ({2'b00, r_addr[31:2]} >= c_DEPTH32);

        if (r_we) begin
            w_bad_width = !((r_funct3 == MW_B) || (r_funct3 == MW_H) || (r_funct3 == MW_W));
        end else begin
            w_bad_width = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) || (r_funct3 == 3'b111);
        end

        case (r_funct3)
            MW_H, MW_HU: w_misalign = r_addr[0];
            MW_W:        w_misalign = (r_addr[1:0] != 2'b00);
            default:     w_misalign = 1'b0;
        endcase

        w_fault = w_oor || w_bad_width || w_misalign;
    end

    mc_load_ext u_load_ext (
        .i_word   (r_rword),
        .i_lane   (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    // Outputs come from registered state only, never from req_*
    assign resp_valid = (r_state == RESP);
    assign resp_fault = resp_valid && w_fault;
    assign resp_rdata = (resp_valid && !r_we && !w_fault) ? w_ext : 32'd0;

    // ------------------------------------------------------------------
    // Store lane steering: data is replicated so every enabled lane sees it
    // ------------------------------------------------------------------
    always_comb begin
        case (r_funct3)
            MW_B: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            MW_H: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            MW_W: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wlane = r_wdata;
            end
        endcase
    end

    // Reset during RESP must discard the pending store, hence the !reset term
    assign w_wr_en  = (r_state == RESP) && r_we && !w_fault && !reset;
    assign w_wr_idx = r_addr[2 +: c_IDX_W];
    assign w_rd_idx = req_addr[2 +: c_IDX_W];

    // ------------------------------------------------------------------
    // Word RAM, byte write enables, registered read at accept. A read can
    // never coincide with a write (accept only in IDLE, write only in RESP),
    // so a load accepted after a store's RESP sees the new data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= w_wlane[8*i +: 8];
                end
            end
        end
        if (w_accept) begin
            r_rword <= r_mem[w_rd_idx];
        end
    end

endmodule : mc_mem_responder
`default_nettype wire

// File: tb/tb_mc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_mem_responder
// Description : Directed self-checking bench for mc_mem_responder. Main
//               instance (WAIT_STATES=1) covers data paths and faults; two
//               extra instances (WAIT_STATES=0 and 3) cover throughput with
//               a continuously held request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_mem_responder;

    localparam int c_DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = 3'b010;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    logic        hold_v = 1'b0;
    logic        rdy0, rv0, flt0;
    logic        rdy3, rv3, flt3;
    logic [31:0] rd0, rd3;

    int checks = 0;
    int errors = 0;

    logic [31:0] t_rd;
    logic        t_flt;
    int          t_lat;
    int          t_rdylow;
    int          t_nresp;

    always #5 clk = ~clk;

    mc_mem_responder #(.DEPTH_WORDS(c_DEPTH), .WAIT_STATES(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
    );

    mc_mem_responder #(.DEPTH_WORDS(c_DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(hold_v), .req_ready(rdy0), .req_we(1'b1),
        .req_addr(32'h0000_0008), .req_wdata(32'h0000_1234), .req_funct3(3'b010),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_fault(flt0)
    );

    mc_mem_responder #(.DEPTH_WORDS(c_DEPTH), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(hold_v), .req_ready(rdy3), .req_we(1'b1),
        .req_addr(32'h0000_0008), .req_wdata(32'h0000_5678), .req_funct3(3'b010),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_fault(flt3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One request on the main instance; records latency, ready-low cycles,
    // response count and the response payload.
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
        int n;
        @(negedge clk);
        req_we     = we;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f3;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        t_lat = 0; t_rdylow = 0; t_nresp = 0; t_rd = '0; t_flt = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (resp_valid) begin
                t_nresp++;
                t_lat = c;
                t_rd  = resp_rdata;
                t_flt = resp_fault;
            end
            if (req_ready) break;
            t_rdylow++;
            @(negedge clk);
        end
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3,
                      input logic [32:0] exp_flt_rd);
        txn(1'b0, a, 32'd0, f3);
        chk(tag, {31'd0, t_flt, t_rd}, {31'd0, exp_flt_rd});
    endtask

    task automatic st(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input logic exp_flt);
        txn(1'b1, a, d, f3);
        chk(tag, {31'd0, t_flt, t_rd}, {31'd0, exp_flt, 32'd0});
    endtask

    initial begin
        int acc0[$], rsp0[$], acc3[$], rsp3[$];
        int nflt, nrv;

        repeat (3) @(negedge clk);
        chk("reset_hold_outputs", {60'd0, req_ready, resp_valid, resp_fault, |resp_rdata},
            {60'd0, 4'b1000});
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state", {28'd0, req_ready, resp_valid, resp_fault, resp_rdata},
            {28'd0, 1'b1, 1'b0, 1'b0, 32'd0});

        // Store then load, with timing checks
        txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        chk("sw_latency", 64'(t_lat), 64'd2);
        chk("sw_ready_low", 64'(t_rdylow), 64'd2);
        chk("sw_resp", {30'd0, 2'(t_nresp), t_flt, t_rd}, {30'd0, 2'd1, 1'b0, 32'd0});
        txn(1'b0, 32'h10, 32'd0, 3'b010);
        chk("lw_latency", 64'(t_lat), 64'd2);
        chk("lw_ready_low", 64'(t_rdylow), 64'd2);
        chk("lw_data", {30'd0, 2'(t_nresp), t_flt, t_rd}, {30'd0, 2'd1, 1'b0, 32'hDEADBEEF});

        // Load extension
        st("sw_0x20", 32'h20, 32'h80FF7F01, 3'b010, 1'b0);
        ld("lb_0x20",  32'h20, 3'b000, {1'b0, 32'h00000001});
        ld("lb_0x23",  32'h23, 3'b000, {1'b0, 32'hFFFFFF80});
        ld("lbu_0x23", 32'h23, 3'b100, {1'b0, 32'h00000080});
        ld("lh_0x22",  32'h22, 3'b001, {1'b0, 32'hFFFF80FF});
        ld("lhu_0x22", 32'h22, 3'b101, {1'b0, 32'h000080FF});
        ld("lh_0x20",  32'h20, 3'b001, {1'b0, 32'h00007F01});

        // Store byte merging
        st("sw_0x30", 32'h30, 32'h11223344, 3'b010, 1'b0);
        st("sb_0x31", 32'h31, 32'h000000AA, 3'b000, 1'b0);
        ld("lw_after_sb", 32'h30, 3'b010, {1'b0, 32'h1122AA44});
        st("sh_0x32", 32'h32, 32'h0000BEEF, 3'b001, 1'b0);
        ld("lw_after_sh", 32'h30, 3'b010, {1'b0, 32'hBEEFAA44});

        // Faults
        ld("lw_misalign_0x05", 32'h05, 3'b010, {1'b1, 32'd0});
        st("sh_misalign_0x07", 32'h07, 32'h0000FFFF, 3'b001, 1'b1);
        ld("lb_f3_011", 32'h20, 3'b011, {1'b1, 32'd0});
        ld("lw_out_of_range", 32'(4 * c_DEPTH), 3'b010, {1'b1, 32'd0});
        st("sb_f3_100_store", 32'h30, 32'h00000077, 3'b100, 1'b1);
        st("sw_0x04", 32'h04, 32'hCAFEF00D, 3'b010, 1'b0);
        st("sw_misalign_0x06", 32'h06, 32'h12345678, 3'b010, 1'b1);
        ld("lw_0x04_unchanged", 32'h04, 3'b010, {1'b0, 32'hCAFEF00D});
        ld("lw_0x30_unchanged", 32'h30, 3'b010, {1'b0, 32'hBEEFAA44});

        // Last word in range
        st("sw_last_word", 32'(4 * c_DEPTH - 4), 32'hA5A55A5A, 3'b010, 1'b0);
        ld("lw_last_word", 32'(4 * c_DEPTH - 4), 3'b010, {1'b0, 32'hA5A55A5A});

        // Reset while a store is waiting
        st("sw_0x40_pre", 32'h40, 32'h11111111, 3'b010, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_funct3 = 3'b010;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_in_wait_busy", {62'd0, req_ready, resp_valid}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_wait_after", {62'd0, req_ready, resp_valid}, 64'b10);
        nrv = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) nrv++;
        end
        chk("rst_in_wait_no_resp", 64'(nrv), 64'd0);
        ld("lw_0x40_pre_value", 32'h40, 3'b010, {1'b0, 32'h11111111});

        // Throughput with request held continuously
        @(negedge clk);
        hold_v = 1'b1;
        nflt = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (rdy0) acc0.push_back(cyc);
            if (rv0) begin rsp0.push_back(cyc); if (flt0 || rd0 != 0) nflt++; end
            if (rdy3) acc3.push_back(cyc);
            if (rv3) begin rsp3.push_back(cyc); if (flt3 || rd3 != 0) nflt++; end
            @(negedge clk);
        end
        hold_v = 1'b0;
        chk("ws0_accepts", 64'(acc0.size()), 64'd15);
        chk("ws0_resps", 64'(rsp0.size()), 64'd15);
        chk("ws3_accepts", 64'(acc3.size()), 64'd6);
        chk("ws3_resps", 64'(rsp3.size()), 64'd6);
        chk("throughput_payload", 64'(nflt), 64'd0);
        for (int i = 0; i < acc0.size() && i < rsp0.size(); i++) begin
            chk("ws0_accept_cycle", 64'(acc0[i]), 64'(2 * i));
            chk("ws0_resp_latency", 64'(rsp0[i] - acc0[i]), 64'd1);
        end
        for (int i = 0; i < acc3.size() && i < rsp3.size(); i++) begin
            chk("ws3_accept_cycle", 64'(acc3[i]), 64'(5 * i));
            chk("ws3_resp_latency", 64'(rsp3[i] - acc3[i]), 64'd4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mc_mem_responder
`default_nettype wire
